// File: rtl/ssemi_adc_output_buffer_pkg.sv
// Shared widths, the transfer-decision bundle and the saturating drop-counter helper
// for the ADC output buffer.
package ssemi_adc_output_buffer_pkg;

   localparam int SSEMI_OUTPUT_DATA_WIDTH     = 24;
   localparam int SSEMI_OUTBUF_DEPTH          = 16;
   localparam int SSEMI_OUTBUF_OUT_WIDTH      = 32;
   localparam int SSEMI_OUTBUF_DROP_CNT_WIDTH = 16;
   localparam int SEQ_TAG_W                   = 8;

   typedef logic [SSEMI_OUTBUF_DROP_CNT_WIDTH-1:0] drop_cnt_t;

   // Per-cycle decisions taken from the registered level and the current inputs.
   typedef struct packed {
      logic wr;
      logic rd;
      logic accept;
      logic drop;
   } xfer_t;

   function automatic drop_cnt_t sat_inc(input drop_cnt_t v);
      return (v == {SSEMI_OUTBUF_DROP_CNT_WIDTH{1'b1}}) ? v
             : v + {{(SSEMI_OUTBUF_DROP_CNT_WIDTH-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/ssemi_adc_output_buffer_if.sv
// Sample-in / word-out handshake bundle of the ADC output buffer. The buffer is the
// slave; the decimator and host side together form the master.
interface ssemi_adc_output_buffer_if
   import ssemi_adc_output_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = SSEMI_OUTPUT_DATA_WIDTH,
   parameter int OUT_WIDTH  = SSEMI_OUTBUF_OUT_WIDTH
);
   logic [DATA_WIDTH-1:0] i_data;
   logic                  i_valid;
   logic [OUT_WIDTH-1:0]  o_data;
   logic                  o_valid;
   logic                  i_ready;

   modport slave  (input  i_data, i_valid, i_ready, output o_data, o_valid);
   modport master (output i_data, i_valid, i_ready, input  o_data, o_valid);
endinterface

// File: rtl/ssemi_outbuf_mem.sv
// Flop-array storage for the output buffer: one write port, one asynchronous read
// port, no reset on the data.
module ssemi_outbuf_mem #(
   parameter int  DEPTH  = 16,
   parameter int  WIDTH  = 24,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [WIDTH-1:0]  i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [WIDTH-1:0]  o_rdata
);
   logic [WIDTH-1:0] mem_q [DEPTH];

   // Store the incoming entry at the write address.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem_q[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = mem_q[i_raddr];
endmodule

// File: rtl/ssemi_adc_output_buffer.sv
// Burst-absorbing FIFO between the ADC decimator and the host bus, with level,
// watermark, overflow and drop-count reporting. Option: SSEMI_OUTBUF_SEQ_TAG_EN.
module ssemi_adc_output_buffer
   import ssemi_adc_output_buffer_pkg::*;
#(
   parameter int  DATA_WIDTH = SSEMI_OUTPUT_DATA_WIDTH,
   parameter int  OUT_WIDTH  = SSEMI_OUTBUF_OUT_WIDTH,
   parameter int  DEPTH      = SSEMI_OUTBUF_DEPTH,
   localparam int ADDR_W     = $clog2(DEPTH)
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_enable,
   input  logic                   i_flush,
   ssemi_adc_output_buffer_if.slave bus,
   input  logic [ADDR_W:0]        i_watermark,
   input  logic                   i_clear_error,
   output logic [ADDR_W:0]        o_level,
   output logic                   o_full,
   output logic                   o_empty,
   output logic                   o_watermark,
   output logic                   o_overflow,
   output drop_cnt_t              o_drop_count
);
`ifdef SSEMI_OUTBUF_SEQ_TAG_EN
   localparam int ENTRY_W = SEQ_TAG_W + DATA_WIDTH;
`else
   localparam int ENTRY_W = DATA_WIDTH;
`endif
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic              overflow_q, overflow_d;
   drop_cnt_t         drop_cnt_q, drop_cnt_d;
   xfer_t             xfer_s;
   logic              full_s, empty_s;
   logic [ENTRY_W-1:0] wdata_s, rdata_s;
   logic [OUT_WIDTH-1:0] word_s;

`ifdef SSEMI_OUTBUF_SEQ_TAG_EN
   logic [SEQ_TAG_W-1:0] seq_q, seq_d;
   assign wdata_s = {seq_q, bus.i_data};
   // The tag already fills the upper bits, so the word is zero-extended.
   assign word_s  = OUT_WIDTH'(rdata_s);
`else
   assign wdata_s = bus.i_data;
   assign word_s  = OUT_WIDTH'($signed(rdata_s));
`endif

   // Transfer decisions: a full buffer only accepts a write when a read frees a slot.
   always_comb begin
      full_s        = (level_q == DEPTH_L);
      empty_s       = (level_q == {(ADDR_W+1){1'b0}});
      xfer_s.wr     = bus.i_valid & i_enable & ~i_flush;
      xfer_s.rd     = ~empty_s & bus.i_ready & ~i_flush;
      xfer_s.accept = xfer_s.wr & (~full_s | xfer_s.rd);
      xfer_s.drop   = xfer_s.wr & full_s & ~xfer_s.rd;
   end

   // Next pointers, level and error state.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      if (i_flush) begin
         wr_ptr_d = {ADDR_W{1'b0}};
         rd_ptr_d = {ADDR_W{1'b0}};
         level_d  = {(ADDR_W+1){1'b0}};
      end else begin
         wr_ptr_d = xfer_s.accept ? wr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1} : wr_ptr_q;
         rd_ptr_d = xfer_s.rd     ? rd_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1} : rd_ptr_q;
         level_d  = level_q + {{ADDR_W{1'b0}}, xfer_s.accept}
                            - {{ADDR_W{1'b0}}, xfer_s.rd};
      end
      // A drop in the same cycle as a clear restarts the count at one.
      if (xfer_s.drop) begin
         overflow_d = 1'b1;
         drop_cnt_d = i_clear_error ? {{(SSEMI_OUTBUF_DROP_CNT_WIDTH-1){1'b0}}, 1'b1}
                                    : sat_inc(drop_cnt_q);
      end else if (i_clear_error) begin
         overflow_d = 1'b0;
         drop_cnt_d = {SSEMI_OUTBUF_DROP_CNT_WIDTH{1'b0}};
      end else begin
         overflow_d = overflow_q;
         drop_cnt_d = drop_cnt_q;
      end
   end

`ifdef SSEMI_OUTBUF_SEQ_TAG_EN
   // Dropped samples advance the tag too, so the consumer sees the gap.
   always_comb begin
      if (xfer_s.accept | xfer_s.drop) begin
         seq_d = seq_q + {{(SEQ_TAG_W-1){1'b0}}, 1'b1};
      end else begin
         seq_d = seq_q;
      end
   end

   // Sequence tag register; flush leaves it running.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         seq_q <= {SEQ_TAG_W{1'b0}};
      end else begin
         seq_q <= seq_d;
      end
   end
`endif

   // State registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_ptr_q   <= {ADDR_W{1'b0}};
         rd_ptr_q   <= {ADDR_W{1'b0}};
         level_q    <= {(ADDR_W+1){1'b0}};
         overflow_q <= 1'b0;
         drop_cnt_q <= {SSEMI_OUTBUF_DROP_CNT_WIDTH{1'b0}};
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   ssemi_outbuf_mem #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_mem (
      .i_clk   (i_clk),
      .i_we    (xfer_s.accept),
      .i_waddr (wr_ptr_q),
      .i_wdata (wdata_s),
      .i_raddr (rd_ptr_q),
      .o_rdata (rdata_s)
   );

   // Unwritten storage is masked so the word reads zero while nothing is buffered.
   assign bus.o_valid  = ~empty_s;
   assign bus.o_data   = empty_s ? {OUT_WIDTH{1'b0}} : word_s;
   assign o_level      = level_q;
   assign o_full       = full_s;
   assign o_empty      = empty_s;
   assign o_watermark  = (i_watermark != {(ADDR_W+1){1'b0}}) & (level_q >= i_watermark);
   assign o_overflow   = overflow_q;
   assign o_drop_count = drop_cnt_q;
endmodule
